vga_capture: RTL and testbench

//   Receive end of the VGA link: samples hsync/vsync/red/green/blue on pixel ticks,

---
 rtl/vga_capture.sv | 172 +++++++++++++++++
 tb/tb_vga_capture.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
// vga_capture: receive end of the VGA link.
// Recovers the raster position from the sync falling edges, samples the centre
// pixel of every SCALING_FACTOR x SCALING_FACTOR block into a shadow buffer, and
// publishes the shadow as a flat image bus once a complete, well-formed frame has
// been seen. Byte i = row*SCREEN_WIDTH+col holds {blue,green,red}.
module vga_capture #(
    parameter int SCREEN_WIDTH   = 20,
    parameter int SCREEN_HEIGHT  = 15,
    parameter int SCALING_FACTOR = 32,
    parameter int HPIXELS        = 800,
    parameter int VLINES         = 521,
    parameter int HBP            = 144,
    parameter int HFP            = 784,
    parameter int VBP            = 31,
    parameter int VFP            = 511
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      divided_clk,
    input  logic                                      hsync,
    input  logic                                      vsync,
    input  logic [2:0]                                red,
    input  logic [2:0]                                green,
    input  logic [1:0]                                blue,
    output logic [8*SCREEN_WIDTH*SCREEN_HEIGHT-1:0]   image,
    output logic                                      frame_valid,
    output logic                                      locked
);

    localparam int IMG_W = 8 * SCREEN_WIDTH * SCREEN_HEIGHT;
    localparam int SUB_W = (SCALING_FACTOR > 2) ? $clog2(SCALING_FACTOR) : 1;
    localparam int HB_W  = $clog2(SCREEN_WIDTH + 1);
    localparam int VB_W  = $clog2(SCREEN_HEIGHT + 1);

    localparam logic [9:0] POS_MAX = 10'd1023;
    localparam logic [9:0] H_LAST  = 10'(HPIXELS - 1);
    localparam logic [9:0] V_LAST  = 10'(VLINES - 1);
    localparam logic [9:0] H_BP    = 10'(HBP);
    localparam logic [9:0] H_FP    = 10'(HFP);
    localparam logic [9:0] V_BP    = 10'(VBP);
    localparam logic [9:0] V_FP    = 10'(VFP);

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SCALING_FACTOR - 1);
    localparam logic [SUB_W-1:0] SUB_MID  = SUB_W'(SCALING_FACTOR / 2);

    logic             hsync_q, vsync_q;
    logic [9:0]       hpos, vpos;
    logic [SUB_W-1:0] hsub, vsub;
    logic [HB_W-1:0]  hblk;
    logic [VB_W-1:0]  vblk;
    logic [IMG_W-1:0] shadow;
    logic             seen_vsync, frame_ok;

    logic             hfall, vfall;
    logic [9:0]       hpos_cur, vpos_cur;
    logic [SUB_W-1:0] hsub_cur, vsub_cur;
    logic [HB_W-1:0]  hblk_cur;
    logic [VB_W-1:0]  vblk_cur;
    logic             line_bad, in_window, capture, publish;
    int               wr_idx;

    // Position of the sample taken on this tick, plus block/offset sub-counters.
    // The sub-counters restart at the first active column/line, so they are only
    // meaningful inside the active window; outside it they free-run harmlessly.
    always_comb begin
        hfall = hsync_q & ~hsync;
        vfall = vsync_q & ~vsync;

        if (hfall)                hpos_cur = '0;
        else if (hpos == POS_MAX) hpos_cur = POS_MAX;
        else                      hpos_cur = hpos + 10'd1;

        if (vfall)                vpos_cur = '0;
        else if (hfall)           vpos_cur = (vpos == POS_MAX) ? POS_MAX : vpos + 10'd1;
        else                      vpos_cur = vpos;

        hsub_cur = hsub;
        hblk_cur = hblk;
        if (hpos_cur == H_BP) begin
            hsub_cur = '0;
            hblk_cur = '0;
        end else if (hsub == SUB_LAST) begin
            hsub_cur = '0;
            hblk_cur = hblk + HB_W'(1);
        end else begin
            hsub_cur = hsub + SUB_W'(1);
        end

        vsub_cur = vsub;
        vblk_cur = vblk;
        if (hfall || vfall) begin
            if (vpos_cur == V_BP) begin
                vsub_cur = '0;
                vblk_cur = '0;
            end else if (vsub == SUB_LAST) begin
                vsub_cur = '0;
                vblk_cur = vblk + VB_W'(1);
            end else begin
                vsub_cur = vsub + SUB_W'(1);
            end
        end

        // The line ending on this tick is checked here so that the last line of
        // a frame counts toward the publish decision taken on the same tick.
        line_bad  = hfall && (hpos != H_LAST);
        in_window = (hpos_cur >= H_BP) && (hpos_cur < H_FP) &&
                    (vpos_cur >= V_BP) && (vpos_cur < V_FP);
        capture   = in_window && (hsub_cur == SUB_MID) && (vsub_cur == SUB_MID);
        publish   = vfall && seen_vsync && frame_ok && !line_bad && (vpos == V_LAST);
        wr_idx    = int'(vblk_cur) * SCREEN_WIDTH + int'(hblk_cur);
    end

    // Sync history and raster position, advanced on pixel ticks only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            hpos    <= '0;
            vpos    <= '0;
            hsub    <= '0;
            hblk    <= '0;
            vsub    <= '0;
            vblk    <= '0;
        end else if (divided_clk) begin
            hsync_q <= hsync;
            vsync_q <= vsync;
            hpos    <= hpos_cur;
            vpos    <= vpos_cur;
            hsub    <= hsub_cur;
            hblk    <= hblk_cur;
            vsub    <= vsub_cur;
            vblk    <= vblk_cur;
        end
    end

    // Shadow frame buffer; never cleared between frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (divided_clk && capture) begin
            shadow[wr_idx*8 +: 8] <= {blue, green, red};
        end
    end

    // Frame qualification and publishing; frame_valid is a single-clock pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            image       <= '0;
            frame_valid <= 1'b0;
            locked      <= 1'b0;
            seen_vsync  <= 1'b0;
            frame_ok    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (divided_clk) begin
                if (line_bad) frame_ok <= 1'b0;
                if (vfall) begin
                    if (publish) begin
                        image       <= shadow;
                        frame_valid <= 1'b1;
                        locked      <= 1'b1;
                    end else begin
                        locked      <= 1'b0;
                    end
                    seen_vsync <= 1'b1;
                    frame_ok   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Testbench for vga_capture using a reduced raster so whole frames stay short.
// A frame generator drives ticks; a reference model keeps the expected shadow as
// a byte array indexed by logical pixel and decides publishing from each frame's
// known well-formedness. Expected images go into a queue popped by a monitor.
module tb_vga_capture;
    localparam int SW = 4, SH = 3, SF = 4;
    localparam int HP = 40, VL = 24, HBP = 8, HFP = 24, VBP = 4, VFP = 16;
    localparam int HSW = 4, VSW = 2, SHORT_LEN = 35;
    localparam int NPIX = SW * SH, IMG_W = 8 * NPIX;
    localparam int MODE_RAND = 0, MODE_PATTERN = 1, MODE_GLITCH = 2;
    localparam int GOOD = 0, SHORT_LINE = 1, MISSING_LINE = 2;

    logic clk = 1'b0, rst_n = 1'b1, divided_clk = 1'b0, hsync = 1'b1, vsync = 1'b1;
    logic [2:0] red = '0, green = '0;
    logic [1:0] blue = '0;
    logic [IMG_W-1:0] image;
    logic frame_valid, locked;

    vga_capture #(
        .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .SCALING_FACTOR(SF),
        .HPIXELS(HP), .VLINES(VL), .HBP(HBP), .HFP(HFP), .VBP(VBP), .VFP(VFP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .divided_clk(divided_clk),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
        .image(image), .frame_valid(frame_valid), .locked(locked)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    logic [7:0] shadow_m [NPIX];
    logic [IMG_W-1:0] last_img = '0;
    logic [IMG_W-1:0] exp_q [$];
    logic [IMG_W-1:0] mon_exp;
    bit m_seen = 1'b0, prev_good = 1'b0;

    task automatic check(input string name, input logic [IMG_W-1:0] act, input logic [IMG_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [IMG_W-1:0] pack_shadow();
        logic [IMG_W-1:0] v;
        for (int i = 0; i < NPIX; i++) v[i*8 +: 8] = shadow_m[i];
        return v;
    endfunction

    function automatic logic [7:0] pixel_for(input int mode, input int x, input int y, input int gx, input int gy);
        if (mode == MODE_PATTERN) begin
            if (x >= HBP && x < HFP && y >= VBP && y < VFP)
                return 8'((y - VBP) / SF * SW + (x - HBP) / SF);
            return 8'($urandom);
        end
        if (mode == MODE_GLITCH) return (x == gx && y == gy) ? 8'h07 : 8'h00;
        return 8'($urandom);
    endfunction

    // A clock with no tick: inputs are scrambled to show they are ignored.
    task automatic idle_clk();
        divided_clk = 1'b0;
        hsync = 1'($urandom);
        vsync = 1'($urandom);
        {blue, green, red} = 8'($urandom);
        @(posedge clk); #1;
    endtask

    task automatic drive_tick(input logic hs, input logic vs, input logic [7:0] pix, input int x, input int y);
        hsync = hs;
        vsync = vs;
        {blue, green, red} = pix;
        divided_clk = 1'b1;
        if (x >= HBP && x < HFP && y >= VBP && y < VFP &&
            (x - HBP) % SF == SF / 2 && (y - VBP) % SF == SF / 2)
            shadow_m[(y - VBP) / SF * SW + (x - HBP) / SF] = pix;
        @(posedge clk); #1;
        divided_clk = 1'b0;
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) idle_clk();
    endtask

    // First tick of a frame (both syncs fall): decides publishing of the frame just ended.
    task automatic boundary_tick();
        bit pub;
        pub = m_seen && prev_good;
        if (pub) begin
            last_img = pack_shadow();
            exp_q.push_back(last_img);
        end
        drive_tick(1'b0, 1'b0, 8'($urandom), 0, 0);
        if (!pub) begin
            check("no_pulse_frame_valid", IMG_W'(frame_valid), '0);
            check("no_pulse_locked", IMG_W'(locked), '0);
            check("no_pulse_image_held", image, last_img);
        end
        m_seen = 1'b1;
    endtask

    task automatic frame_body(input int mode, input int kind, input int stop_line,
                              input int gx, input int gy, input bit stall);
        int nlines;
        nlines = (kind == MISSING_LINE) ? VL - 1 : VL;
        for (int y = 0; y < nlines; y++) begin
            int len;
            if (y == stop_line) return;
            len = (kind == SHORT_LINE && y == VL - 3) ? SHORT_LEN : HP;
            for (int x = (y == 0) ? 1 : 0; x < len; x++) begin
                drive_tick(x >= HSW, y >= VSW, pixel_for(mode, x, y, gx, gy), x, y);
                if (stall && y == VBP + 5 && x == HBP + 6) repeat (1000) idle_clk();
            end
        end
        prev_good = (kind == GOOD);
    endtask

    // Scoreboard monitor: every frame_valid pulse must match a queued expectation.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame_valid", IMG_W'(frame_valid), '0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("published_image", image, mon_exp);
                check("locked_on_publish", IMG_W'(locked), IMG_W'(1));
            end
        end
    end

    initial begin
        logic [IMG_W-1:0] pattern;
        for (int i = 0; i < NPIX; i++) begin
            shadow_m[i] = 8'h00;
            pattern[i*8 +: 8] = 8'(i);
        end

        // Reset held with live, ticking inputs.
        #1 rst_n = 1'b0;
        for (int k = 0; k < 12; k++) begin
            divided_clk = 1'b1;
            hsync = 1'($urandom);
            vsync = 1'($urandom);
            {blue, green, red} = 8'($urandom);
            @(posedge clk); #1;
            if (k % 3 == 2) begin
                check("reset_image", image, '0);
                check("reset_frame_valid", IMG_W'(frame_valid), '0);
                check("reset_locked", IMG_W'(locked), '0);
            end
        end
        divided_clk = 1'b0;
        hsync = 1'b1;
        vsync = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // F1 pattern: first vsync fall after reset never publishes.
        boundary_tick();
        frame_body(MODE_PATTERN, GOOD, -1, 0, 0, 1'b0);
        // F2 random with a long stall mid-line; its start publishes F1.
        boundary_tick();
        check("pattern_image", image, pattern);
        frame_body(MODE_RAND, GOOD, -1, 0, 0, 1'b1);
        // F3 has a short line.
        boundary_tick();
        frame_body(MODE_RAND, SHORT_LINE, -1, 0, 0, 1'b0);
        // F4 good, F3 rejected at its start.
        boundary_tick();
        frame_body(MODE_RAND, GOOD, -1, 0, 0, 1'b0);
        // F5 is one line short.
        boundary_tick();
        frame_body(MODE_RAND, MISSING_LINE, -1, 0, 0, 1'b0);
        // F6: red=7 only at a non-sample column.
        boundary_tick();
        frame_body(MODE_GLITCH, GOOD, -1, HBP + 3, VBP + SF / 2, 1'b0);
        // F7: red=7 at the sample point of block 0.
        boundary_tick();
        check("nonsample_glitch_byte0", IMG_W'(image[7:0]), '0);
        frame_body(MODE_GLITCH, GOOD, -1, HBP + SF / 2, VBP + SF / 2, 1'b0);
        // F8: partial frame then reset.
        boundary_tick();
        check("sample_glitch_byte0", IMG_W'(image[7:0]), IMG_W'(8'h07));
        frame_body(MODE_RAND, GOOD, VBP + 6, 0, 0, 1'b0);

        rst_n = 1'b0;
        #1;
        check("midreset_image", image, '0);
        check("midreset_frame_valid", IMG_W'(frame_valid), '0);
        check("midreset_locked", IMG_W'(locked), '0);
        for (int i = 0; i < NPIX; i++) shadow_m[i] = 8'h00;
        last_img = '0;
        m_seen = 1'b0;
        prev_good = 1'b0;
        repeat (3) idle_clk();
        hsync = 1'b1;
        vsync = 1'b1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // F9, F10 random; relock after two vsync falls.
        boundary_tick();
        frame_body(MODE_RAND, GOOD, -1, 0, 0, 1'b0);
        boundary_tick();
        frame_body(MODE_RAND, GOOD, -1, 0, 0, 1'b0);
        boundary_tick();
        repeat (4) idle_clk();

        check("pending_publishes", IMG_W'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
